// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master arbiter and sequencer for the 8-bit peripheral bus.
//
// Shares one peripheral address/data/strobe bus between port A (processor core) and port B
// (secondary master). Requests are latched in IDLE, driven to the peripheral in ACCESS until
// i_peripReady, and acknowledged to the granted master for one cycle in ACK. When both masters
// request at once, the one not granted last wins; the first such tie after reset goes to A.
//
// Ports:
//   i_clk, i_rst                 clock (rising edge), synchronous active-low reset
//   i_aReq/i_aWr/i_aAddr/i_aWData  port A request, direction, address, write data
//   o_aAck/o_aRData                port A one-cycle completion pulse and read data
//   i_bReq ... o_bRData            same as port A, for port B
//   o_peripAddr/o_peripDataFromCPU peripheral address and write data (registered)
//   o_peripWrSig/o_peripRdSig      peripheral strobes, high only in ACCESS
//   i_peripDataToCPU/i_peripReady  peripheral read data and completion
//   o_busy                         high whenever the FSM is not in IDLE
//   o_err                          one-cycle timeout pulse, coincident with the ack
//
// Build option: define PERIPH_ARB_TIMEOUT_EN to abort an access after TIMEOUT ACCESS cycles
// without ready (rdata = all ones, o_err = 1). Without it ACCESS waits forever, o_err is 0.

module periph_bus_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_aReq,
    input  logic              i_aWr,
    input  logic [ADDR_W-1:0] i_aAddr,
    input  logic [DATA_W-1:0] i_aWData,
    output logic              o_aAck,
    output logic [DATA_W-1:0] o_aRData,
    input  logic              i_bReq,
    input  logic              i_bWr,
    input  logic [ADDR_W-1:0] i_bAddr,
    input  logic [DATA_W-1:0] i_bWData,
    output logic              o_bAck,
    output logic [DATA_W-1:0] o_bRData,
    output logic [ADDR_W-1:0] o_peripAddr,
    output logic [DATA_W-1:0] o_peripDataFromCPU,
    output logic              o_peripWrSig,
    output logic              o_peripRdSig,
    input  logic [DATA_W-1:0] i_peripDataToCPU,
    input  logic              i_peripReady,
    output logic              o_busy,
    output logic              o_err
);

    if (TIMEOUT < 1) begin : gBadTimeout
        $error("periph_bus_arbiter: TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

    state_e stateQ, stateD;

    logic              gntBQ;    // master owning the current access: 1 = B
    logic              prioBQ;   // master favoured on a tie: 1 = B
    logic              wrQ;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] aRDataQ, bRDataQ;

    logic              selB;
    logic              timeoutHit;
    logic              accessDone;
    logic [DATA_W-1:0] doneData;

    assign selB = i_bReq & (~i_aReq | prioBQ);

`ifdef PERIPH_ARB_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cntQ;
    logic            errQ;

    // Fires on the ACCESS cycle whose count would reach TIMEOUT; ready on that cycle wins.
    assign timeoutHit = (stateQ == StAccess) && !i_peripReady && (cntQ == CntLast);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cntQ <= '0;
            errQ <= 1'b0;
        end else begin
            errQ <= timeoutHit;
            if (stateQ != StAccess) begin
                cntQ <= '0;
            end else if (!i_peripReady) begin
                cntQ <= cntQ + CntW'(1);
            end
        end
    end

    assign o_err = errQ;
`else
    assign timeoutHit = 1'b0;
    assign o_err      = 1'b0;
`endif

    assign accessDone = i_peripReady | timeoutHit;
    assign doneData   = i_peripReady ? (wrQ ? '0 : i_peripDataToCPU) : '1;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StIdle:   if (i_aReq || i_bReq) stateD = StAccess;
            StAccess: if (accessDone) stateD = StAck;
            StAck:    stateD = StIdle;
            default:  stateD = StIdle;
        endcase
    end

    // Datapath: request latch, read-data return, round-robin update
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            gntBQ   <= 1'b0;
            prioBQ  <= 1'b0;
            wrQ     <= 1'b0;
            addrQ   <= '0;
            wdataQ  <= '0;
            aRDataQ <= '0;
            bRDataQ <= '0;
        end else begin
            // Read data is only presented during the ack cycle.
            aRDataQ <= '0;
            bRDataQ <= '0;
            case (stateQ)
                StIdle: begin
                    if (i_aReq || i_bReq) begin
                        gntBQ  <= selB;
                        wrQ    <= selB ? i_bWr    : i_aWr;
                        addrQ  <= selB ? i_bAddr  : i_aAddr;
                        wdataQ <= selB ? i_bWData : i_aWData;
                    end
                end
                StAccess: begin
                    if (accessDone) begin
                        if (gntBQ) bRDataQ <= doneData;
                        else       aRDataQ <= doneData;
                    end
                end
                StAck: prioBQ <= ~gntBQ;
                default: ;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        o_peripWrSig = 1'b0;
        o_peripRdSig = 1'b0;
        o_aAck       = 1'b0;
        o_bAck       = 1'b0;
        o_busy       = (stateQ != StIdle);
        case (stateQ)
            StAccess: begin
                o_peripWrSig = wrQ;
                o_peripRdSig = ~wrQ;
            end
            StAck: begin
                o_aAck = ~gntBQ;
                o_bAck = gntBQ;
            end
            default: ;
        endcase
    end

    assign o_peripAddr        = addrQ;
    assign o_peripDataFromCPU = wdataQ;
    assign o_aRData           = aRDataQ;
    assign o_bRData           = bRDataQ;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
module tb_periph_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       aReq, aWr, bReq, bWr;
    logic [7:0] aAddr, aWData, bAddr, bWData;
    logic       aAck, bAck;
    logic [7:0] aRData, bRData;
    logic [7:0] peripAddr, peripDataFromCPU, peripDataToCPU;
    logic       peripWrSig, peripRdSig, peripReady;
    logic       busy, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       isB;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    periph_bus_arbiter #(
        .ADDR_W (8),
        .DATA_W (8),
        .TIMEOUT(4)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_aReq            (aReq),
        .i_aWr             (aWr),
        .i_aAddr           (aAddr),
        .i_aWData          (aWData),
        .o_aAck            (aAck),
        .o_aRData          (aRData),
        .i_bReq            (bReq),
        .i_bWr             (bWr),
        .i_bAddr           (bAddr),
        .i_bWData          (bWData),
        .o_bAck            (bAck),
        .o_bRData          (bRData),
        .o_peripAddr       (peripAddr),
        .o_peripDataFromCPU(peripDataFromCPU),
        .o_peripWrSig      (peripWrSig),
        .o_peripRdSig      (peripRdSig),
        .i_peripDataToCPU  (peripDataToCPU),
        .i_peripReady      (peripReady),
        .o_busy            (busy),
        .o_err             (err)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] allOut();
        return {26'd0, peripAddr, peripDataFromCPU, peripWrSig, peripRdSig, aAck, bAck,
                aRData, bRData, busy, err};
    endfunction

    // Steps until an ack appears; counts strobe cycles seen on the way.
    task automatic waitAck(input int budget, output int lat, output int wrCyc, output int rdCyc);
        lat   = 0;
        wrCyc = 0;
        rdCyc = 0;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (aAck || bAck) begin
                lat = i;
                return;
            end
            if (peripWrSig) wrCyc++;
            if (peripRdSig) rdCyc++;
        end
        checks++;
        errors++;
        $error("FAIL waitAck observed=no ack expected=ack within %0d cycles", budget);
    endtask

    task automatic popCheck(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=ack expected=empty scoreboard", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".acks"}, {62'd0, aAck, bAck}, {62'd0, ~e.isB, e.isB});
        chk({tag, ".rdata"}, {56'd0, (e.isB ? bRData : aRData)}, {56'd0, e.rdata});
        chk({tag, ".err"}, {63'd0, err}, {63'd0, e.err});
    endtask

    initial begin
        int lat, wrCyc, rdCyc;

        rst = 1'b0;
        aReq = 1'b0; aWr = 1'b0; aAddr = '0; aWData = '0;
        bReq = 1'b0; bWr = 1'b0; bAddr = '0; bWData = '0;
        peripReady = 1'b0; peripDataToCPU = '0;

        // Reset then idle
        step();
        step();
        rst = 1'b1;
        chk("reset.outputs", allOut(), 64'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle.outputs", allOut(), 64'd0);
        end

        // Port A write, ready tied high
        peripReady = 1'b1;
        aReq = 1'b1; aWr = 1'b1; aAddr = 8'h10; aWData = 8'h5A;
        sb.push_back('{isB: 1'b0, rdata: 8'h00, err: 1'b0});
        step();
        chk("aw.wrSig", {63'd0, peripWrSig}, 64'd1);
        chk("aw.rdSig", {63'd0, peripRdSig}, 64'd0);
        chk("aw.addr", {56'd0, peripAddr}, 64'h10);
        chk("aw.data", {56'd0, peripDataFromCPU}, 64'h5A);
        chk("aw.busy", {63'd0, busy}, 64'd1);
        step();
        popCheck("aw");
        chk("aw.wrSigDrop", {63'd0, peripWrSig}, 64'd0);
        aReq = 1'b0;
        step();
        chk("aw.idle", {63'd0, busy}, 64'd0);

        // Port B read, ready on the third ACCESS cycle
        peripReady = 1'b0;
        bReq = 1'b1; bWr = 1'b0; bAddr = 8'h20; bWData = 8'hEE;
        sb.push_back('{isB: 1'b1, rdata: 8'hC3, err: 1'b0});
        for (int i = 0; i < 3; i++) begin
            step();
            chk("br.rdSig", {62'd0, peripRdSig, peripWrSig}, 64'd2);
            chk("br.addr", {56'd0, peripAddr}, 64'h20);
            chk("br.noAck", {62'd0, aAck, bAck}, 64'd0);
        end
        peripReady = 1'b1; peripDataToCPU = 8'hC3;
        step();
        popCheck("br");
        bReq = 1'b0;
        step();

        // Contention after reset: grants alternate A, B, A, B
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        peripReady = 1'b1; peripDataToCPU = 8'h3C;
        aReq = 1'b1; aWr = 1'b1; aAddr = 8'h01; aWData = 8'h11;
        bReq = 1'b1; bWr = 1'b0; bAddr = 8'h02; bWData = 8'h22;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{isB: (k % 2 == 1), rdata: ((k % 2 == 1) ? 8'h3C : 8'h00), err: 1'b0});
        end
        for (int k = 0; k < 4; k++) begin
            waitAck(6, lat, wrCyc, rdCyc);
            chk("cont.latency", 64'(lat), 64'd2);
            chk("cont.strobeCycles", 64'(wrCyc + rdCyc), 64'd1);
            popCheck("cont");
            if (aAck) aReq = 1'b0;
            if (bAck) bReq = 1'b0;
            step();
            chk("cont.gapIdle", {63'd0, busy}, 64'd0);
            if (k < 2) begin
                aReq = 1'b1;
                bReq = 1'b1;
            end
        end

        // Reset in the middle of an access
        aReq = 1'b0; bReq = 1'b0;
        peripReady = 1'b0;
        aReq = 1'b1; aWr = 1'b0; aAddr = 8'h44;
        step();
        chk("rst.rdSig", {63'd0, peripRdSig}, 64'd1);
        rst = 1'b0;
        step();
        chk("rst.strobes", {62'd0, peripWrSig, peripRdSig}, 64'd0);
        chk("rst.acks", {62'd0, aAck, bAck}, 64'd0);
        chk("rst.busy", {63'd0, busy}, 64'd0);
        chk("rst.addr", {56'd0, peripAddr}, 64'd0);
        rst = 1'b1;
        peripReady = 1'b1; peripDataToCPU = 8'h99;
        sb.push_back('{isB: 1'b0, rdata: 8'h99, err: 1'b0});
        waitAck(6, lat, wrCyc, rdCyc);
        chk("reissue.latency", 64'(lat), 64'd2);
        popCheck("reissue");
        aReq = 1'b0;
        step();

`ifdef PERIPH_ARB_TIMEOUT_EN
        // Timeout: A read with ready held low, then a normal B access
        peripReady = 1'b0;
        aReq = 1'b1; aWr = 1'b0; aAddr = 8'h55;
        sb.push_back('{isB: 1'b0, rdata: 8'hFF, err: 1'b1});
        waitAck(12, lat, wrCyc, rdCyc);
        chk("to.latency", 64'(lat), 64'd5);
        chk("to.rdCycles", 64'(rdCyc), 64'd4);
        popCheck("to");
        aReq = 1'b0;
        step();
        chk("to.errPulse", {63'd0, err}, 64'd0);
        peripReady = 1'b1; peripDataToCPU = 8'h77;
        bReq = 1'b1; bWr = 1'b0; bAddr = 8'h66;
        sb.push_back('{isB: 1'b1, rdata: 8'h77, err: 1'b0});
        waitAck(6, lat, wrCyc, rdCyc);
        chk("toB.latency", 64'(lat), 64'd2);
        popCheck("toB");
        bReq = 1'b0;
        step();
`endif

        chk("sb.drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
